// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write queue.
package rf_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  // One pending register write: destination and value.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rf_wr_t;

  // r0 is hard-wired zero, so writes to it are never queued or forwarded.
  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return (addr == REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_write_queue_if.sv
// Request (ALU, load) and register-file write-port bundle of the write queue.
interface rf_write_queue_if;
  import rf_pkg::*;

  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_ready;

  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ready;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_ready;

  // The write queue itself.
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    output rf_we, rf_waddr, rf_wdata,
    input  rf_ready
  );

  // Producers of requests and the register file side.
  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    input  rf_we, rf_waddr, rf_wdata,
    output rf_ready
  );

endinterface

// File: rtl/rf_wq_fifo.sv
// In-order storage for pending register writes: entry array, wrapping
// read/write pointers and an occupancy count that separates full from empty.
module rf_wq_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  rf_wr_t                   push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
  output rf_wr_t [DEPTH-1:0]       entries_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  rf_wr_t [DEPTH-1:0] mem_q;
  logic               do_push_s;
  logic               do_pop_s;

  // Next-state for pointers and count; pushes into a full queue and pops of an
  // empty one are ignored so the count can never wrap.
  always_comb begin
    do_push_s = push_i && (count_q != CW'(DEPTH));
    do_pop_s  = pop_i && (count_q != '0);
    wr_ptr_d  = do_push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful where the count says so.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o   = count_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/rf_write_queue.sv
// Write-side front end of the register file: arbitrates ALU/load requests
// (load first), drops r0 writes, drains the queue head into the write port and
// lets decode read through writes that have not landed yet.
module rf_write_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rf_write_queue_if.slave        bus,
  input  logic [AW-1:0]          rd_addr1_i,
  input  logic [AW-1:0]          rd_addr2_i,
  output logic                   pend1_o,
  output logic                   pend2_o,
  output logic [DW-1:0]          fwd1_o,
  output logic [DW-1:0]          fwd2_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      count_s;
  logic [PW-1:0]      rd_ptr_s;
  rf_wr_t [DEPTH-1:0] entries_s;
  rf_wr_t             head_s;
  rf_wr_t             push_data_s;
  logic               push_s;
  logic               full_s;
  logic               mem_acc_s;
  logic               alu_acc_s;
  logic               we_s;
  logic               hit1_s;
  logic               hit2_s;

  // Enqueue arbitration. Readiness looks only at the current count, so a full
  // queue refuses even when the head is leaving this cycle.
  always_comb begin
    full_s        = (count_s == CW'(DEPTH));
    bus.mem_ready = !full_s;
    bus.alu_ready = !full_s && !bus.mem_valid;
    mem_acc_s     = bus.mem_valid && !full_s;
    alu_acc_s     = bus.alu_valid && !full_s && !bus.mem_valid;
    if (mem_acc_s) begin
      push_data_s = '{addr: bus.mem_addr, data: bus.mem_data};
      push_s      = !is_zero_reg(bus.mem_addr);
    end else begin
      push_data_s = '{addr: bus.alu_addr, data: bus.alu_data};
      push_s      = alu_acc_s && !is_zero_reg(bus.alu_addr);
    end
  end

  rf_wq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (we_s && bus.rf_ready),
    .count_o     (count_s),
    .rd_ptr_o    (rd_ptr_s),
    .entries_o   (entries_s)
  );

  assign head_s  = entries_s[rd_ptr_s];
  assign count_o = count_s;

  // Drain port: head entry straight from storage, forced to zero when empty
  // so stale storage never reaches the register file pins.
  always_comb begin
    we_s      = (count_s != '0);
    bus.rf_we = we_s;
    if (we_s) begin
      bus.rf_waddr = head_s.addr;
      bus.rf_wdata = head_s.data;
    end else begin
      bus.rf_waddr = '0;
      bus.rf_wdata = '0;
    end
  end

  // Lookup/forward: walk valid entries oldest to youngest so the last match
  // seen (the youngest) supplies the forwarded data.
  always_comb begin
    pend1_o = 1'b0;
    pend2_o = 1'b0;
    fwd1_o  = '0;
    fwd2_o  = '0;
    hit1_s  = 1'b0;
    hit2_s  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1_s  = (CW'(i) < count_s) && !is_zero_reg(rd_addr1_i) &&
                (entries_s[rd_ptr_s + PW'(i)].addr == rd_addr1_i);
      hit2_s  = (CW'(i) < count_s) && !is_zero_reg(rd_addr2_i) &&
                (entries_s[rd_ptr_s + PW'(i)].addr == rd_addr2_i);
      pend1_o = pend1_o | hit1_s;
      pend2_o = pend2_o | hit2_s;
      fwd1_o  = hit1_s ? entries_s[rd_ptr_s + PW'(i)].data : fwd1_o;
      fwd2_o  = hit2_s ? entries_s[rd_ptr_s + PW'(i)].data : fwd2_o;
    end
  end

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed bench for rf_write_queue: inputs change on the falling edge, outputs
// are checked 1ns later, well away from the rising edge.
module tb_rf_write_queue;
  import rf_pkg::*;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          pend1;
  logic          pend2;
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;
  logic [2:0]    count;

  int tests_run;
  int tests_failed;

  rf_write_queue_if bus ();

  rf_write_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .rd_addr1_i (rd_addr1),
    .rd_addr2_i (rd_addr2),
    .pend1_o    (pend1),
    .pend2_o    (pend2),
    .fwd1_o     (fwd1),
    .fwd2_o     (fwd2),
    .count_o    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_addr = 5'd0; bus.alu_data = 32'd0;
    bus.mem_valid = 1'b0; bus.mem_addr = 5'd0; bus.mem_data = 32'd0;
    bus.rf_ready = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we got %0h want 0", bus.rf_we); end
    tests_run++; if (bus.rf_waddr !== 5'd0) begin tests_failed++; $display("FAIL reset_waddr got %0h want 0", bus.rf_waddr); end
    tests_run++; if (bus.rf_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset_wdata got %0h want 0", bus.rf_wdata); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h64; bus.rf_ready = 1'b1;
    #1;
    tests_run++; if (bus.alu_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_alu_ready got %0h want 1", bus.alu_ready); end
    @(negedge clk);
    bus.alu_valid = 1'b0;
    #1;
    tests_run++; if (bus.rf_we !== 1'b1) begin tests_failed++; $display("FAIL basic_we got %0h want 1", bus.rf_we); end
    tests_run++; if (bus.rf_waddr !== 5'd3) begin tests_failed++; $display("FAIL basic_waddr got %0h want 3", bus.rf_waddr); end
    tests_run++; if (bus.rf_wdata !== 32'h64) begin tests_failed++; $display("FAIL basic_wdata got %0h want 64", bus.rf_wdata); end
    @(negedge clk);
    #1;
    tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL basic_we_after got %0h want 0", bus.rf_we); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL basic_count_after got %0d want 0", count); end
    @(negedge clk);
    bus.rf_ready = 1'b0;
  endtask

  task automatic test_full_drain();
    bus.rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 5'(i); bus.alu_data = 32'h100 + 32'(i);
      @(negedge clk);
    end
    bus.alu_valid = 1'b0;
    #1;
    tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL full_count got %0d want 4", count); end
    tests_run++; if (bus.alu_ready !== 1'b0) begin tests_failed++; $display("FAIL full_alu_ready got %0h want 0", bus.alu_ready); end
    tests_run++; if (bus.mem_ready !== 1'b0) begin tests_failed++; $display("FAIL full_mem_ready got %0h want 0", bus.mem_ready); end
    // full queue with a dequeue pending must still refuse the load
    bus.rf_ready = 1'b1; bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 32'h99;
    #1;
    tests_run++; if (bus.mem_ready !== 1'b0) begin tests_failed++; $display("FAIL full_no_passthru got %0h want 0", bus.mem_ready); end
    for (int k = 1; k <= 4; k++) begin
      tests_run++; if (bus.rf_we !== 1'b1) begin tests_failed++; $display("FAIL drain%0d_we got %0h want 1", k, bus.rf_we); end
      tests_run++; if (bus.rf_waddr !== 5'(k)) begin tests_failed++; $display("FAIL drain%0d_waddr got %0h want %0h", k, bus.rf_waddr, k); end
      tests_run++; if (bus.rf_wdata !== 32'h100 + 32'(k)) begin tests_failed++; $display("FAIL drain%0d_wdata got %0h want %0h", k, bus.rf_wdata, 32'h100 + 32'(k)); end
      tests_run++; if (count !== 3'(5 - k)) begin tests_failed++; $display("FAIL drain%0d_count got %0d want %0d", k, count, 5 - k); end
      @(negedge clk);
      bus.mem_valid = 1'b0;
      #1;
    end
    tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL drain_done_we got %0h want 0", bus.rf_we); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL drain_done_count got %0d want 0", count); end
    @(negedge clk);
    bus.rf_ready = 1'b0;
  endtask

  task automatic test_priority();
    bus.rf_ready = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd5; bus.mem_data = 32'hAA;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd6; bus.alu_data = 32'hBB;
    #1;
    tests_run++; if (bus.mem_ready !== 1'b1) begin tests_failed++; $display("FAIL prio_mem_ready got %0h want 1", bus.mem_ready); end
    tests_run++; if (bus.alu_ready !== 1'b0) begin tests_failed++; $display("FAIL prio_alu_ready got %0h want 0", bus.alu_ready); end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    #1;
    tests_run++; if (bus.alu_ready !== 1'b1) begin tests_failed++; $display("FAIL prio_alu_ready2 got %0h want 1", bus.alu_ready); end
    tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL prio_count1 got %0d want 1", count); end
    @(negedge clk);
    bus.alu_valid = 1'b0;
    #1;
    tests_run++; if (count !== 3'd2) begin tests_failed++; $display("FAIL prio_count2 got %0d want 2", count); end
    tests_run++; if (bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hAA) begin tests_failed++; $display("FAIL prio_first got %0h/%0h want 5/aa", bus.rf_waddr, bus.rf_wdata); end
    bus.rf_ready = 1'b1;
    @(negedge clk);
    #1;
    tests_run++; if (bus.rf_waddr !== 5'd6 || bus.rf_wdata !== 32'hBB) begin tests_failed++; $display("FAIL prio_second got %0h/%0h want 6/bb", bus.rf_waddr, bus.rf_wdata); end
    @(negedge clk);
    #1;
    tests_run++; if (count !== 3'd0 || bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL prio_empty got count %0d we %0h want 0/0", count, bus.rf_we); end
    bus.rf_ready = 1'b0;
  endtask

  task automatic test_forward();
    bus.rf_ready = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h11;
    @(negedge clk);
    bus.alu_addr = 5'd7; bus.alu_data = 32'h22;
    @(negedge clk);
    bus.alu_addr = 5'd9; bus.alu_data = 32'h33;
    @(negedge clk);
    bus.alu_addr = 5'd10; bus.alu_data = 32'h44;
    rd_addr1 = 5'd7; rd_addr2 = 5'd8;
    #1;
    tests_run++; if (pend1 !== 1'b1 || fwd1 !== 32'h22) begin tests_failed++; $display("FAIL fwd_youngest got %0h/%0h want 1/22", pend1, fwd1); end
    tests_run++; if (pend2 !== 1'b0 || fwd2 !== 32'h0) begin tests_failed++; $display("FAIL fwd_miss got %0h/%0h want 0/0", pend2, fwd2); end
    rd_addr2 = 5'd10;
    #1;
    tests_run++; if (pend2 !== 1'b0) begin tests_failed++; $display("FAIL fwd_same_cycle got %0h want 0", pend2); end
    @(negedge clk);
    bus.alu_valid = 1'b0;
    #1;
    tests_run++; if (pend2 !== 1'b1 || fwd2 !== 32'h44) begin tests_failed++; $display("FAIL fwd_r10 got %0h/%0h want 1/44", pend2, fwd2); end
    rd_addr2 = 5'd9;
    #1;
    tests_run++; if (pend2 !== 1'b1 || fwd2 !== 32'h33) begin tests_failed++; $display("FAIL fwd_r9 got %0h/%0h want 1/33", pend2, fwd2); end
    bus.rf_ready = 1'b1;
    @(negedge clk);
    bus.rf_ready = 1'b0;
    #1;
    tests_run++; if (pend1 !== 1'b1 || fwd1 !== 32'h22 || count !== 3'd3) begin tests_failed++; $display("FAIL fwd_after_pop1 got %0h/%0h/%0d want 1/22/3", pend1, fwd1, count); end
    bus.rf_ready = 1'b1;
    @(negedge clk);
    bus.rf_ready = 1'b0;
    #1;
    tests_run++; if (pend1 !== 1'b0 || fwd1 !== 32'h0) begin tests_failed++; $display("FAIL fwd_after_pop2 got %0h/%0h want 0/0", pend1, fwd1); end
    bus.rf_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.rf_ready = 1'b0;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #1;
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL fwd_drained got %0d want 0", count); end
    @(negedge clk);
  endtask

  task automatic test_zero_reg();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'hFFFF;
    rd_addr1 = 5'd0;
    #1;
    tests_run++; if (bus.alu_ready !== 1'b1) begin tests_failed++; $display("FAIL zero_ready got %0h want 1", bus.alu_ready); end
    @(negedge clk);
    bus.alu_valid = 1'b0;
    #1;
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL zero_count got %0d want 0", count); end
    tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL zero_we got %0h want 0", bus.rf_we); end
    tests_run++; if (pend1 !== 1'b0) begin tests_failed++; $display("FAIL zero_pend got %0h want 0", pend1); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.rf_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 5'(i); bus.alu_data = 32'hA0 + 32'(i);
      @(negedge clk);
    end
    bus.alu_valid = 1'b0;
    rd_addr1 = 5'd2;
    #1;
    tests_run++; if (count !== 3'd3 || pend1 !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre got %0d/%0h want 3/1", count, pend1); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0) begin tests_failed++; $display("FAIL rstmid_we got %0h/%0h want 0/0", bus.rf_we, bus.rf_waddr); end
    tests_run++; if (count !== 3'd0 || pend1 !== 1'b0) begin tests_failed++; $display("FAIL rstmid_count got %0d/%0h want 0/0", count, pend1); end
    @(negedge clk);
    rst_n = 1'b1;
    rd_addr1 = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd12; bus.alu_data = 32'h55; bus.rf_ready = 1'b1;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    #1;
    tests_run++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd12 || bus.rf_wdata !== 32'h55) begin tests_failed++; $display("FAIL rstmid_new got %0h/%0h/%0h want 1/c/55", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL rstmid_new_count got %0d want 1", count); end
    @(negedge clk);
    #1;
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL rstmid_final got %0d want 0", count); end
    bus.rf_ready = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_full_drain();
    test_priority();
    test_forward();
    test_zero_reg();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
